hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//  Hazard and issue scheduler for the 5-stage forwarding (redirect) pipeline.
//  - Sits beside the decode controller.
//  - Tracks destination registers in flight in the EX/MEM/WB stages.
//  - Issues registered forwarding selects for the instruction entering EX.
//  - Handles load-use stalls, branch-redirect flushes and syscall halt-drain.
// PARAMETERS
//  REDIR_CYC  1   cycles flush_ifid stays high after a redirect (>=1)
//  CNT_W      16  width of the saturating stall/flush performance counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  id_valid     in   1      ID stage holds a valid instruction
//  id_rs        in   5      source register A of the ID instruction
//  id_rt        in   5      source register B of the ID instruction
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  id_wr_en     in   1      ID instruction writes a register
//  id_wr_reg    in   5      destination register of the ID instruction
//  id_is_load   in   1      ID instruction is lw/lbu (op 100011/100100)
//  id_halt      in   1      ID instruction is syscall-halt
//  ex_redirect  in   1      branch/jump resolved taken in EX this cycle
//  stall_ifid   out  1      hold PC and IF/ID this cycle (combinational)
//  bubble_ex    out  1      load NOP into ID/EX this cycle (combinational)
//  flush_ifid   out  1      squash IF/ID contents (combinational)
//  fwd_a        out  2      EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB (registered)
//  fwd_b        out  2      EX operand B source, same encoding (registered)
//  halted       out  1      pipeline drained after halt (registered)
//  evt_cnt      out  CNT_W  saturating count of stall+flush cycles (registered)
// BEHAVIOUR
//  Reset:
//   - state=RUN; all tracking valids 0; fwd_a=fwd_b=00; halted=0; evt_cnt=0.
//   - Redirect counter cleared.
//  Tracking:
//   - Three slots, each holding v, rd, ld: EX, MEM, WB.
//   - Every cycle, unless HALTED: WB<-MEM, MEM<-EX.
//   - EX<-ID fields when issue=1, else EX<-invalid.
//   - issue = id_valid & ~stall & ~flush & state!=HALTED.
//   - A match needs v=1, rd!=0, wr_en=1, and a used source equal to rd.
//  Load-use stall:
//   - Raised when the EX slot is a load matching rs or rt.
//   - Drives stall_ifid=1 and bubble_ex=1 in the same cycle.
//  Forwarding (computed from the ID instruction, registered on issue):
//   - EX match (non-load) -> 01.
//   - Else MEM match -> 10.
//   - Else 00 (WB written first half-cycle).
//   - Youngest match wins.
//   - When not issuing, fwd_a/fwd_b are loaded with 00.
//  Redirect:
//   - ex_redirect=1 -> flush_ifid=1 and bubble_ex=1 that cycle, for REDIR_CYC cycles total.
//   - Redirect overrides a simultaneous load-use stall: stall_ifid=0.
//   - A redirect arriving during an active flush restarts the count.
//  FSM states: RUN, DRAIN, HALTED.
//   - RUN->DRAIN: when issuing with id_halt=1. The halt instruction itself is issued.
//   - In DRAIN, issue=0 and stall_ifid=1.
//   - DRAIN->RUN: on ex_redirect (older branch kills the halt); flush as above.
//   - DRAIN->HALTED: when EX, MEM and WB slots are all invalid.
//   - In HALTED: halted=1, stall_ifid=1, bubble_ex=1, slots frozen. Left only by rst.
//  evt_cnt:
//   - +1 on each cycle with stall_ifid|flush_ifid while in RUN.
//   - Holds at 2^CNT_W-1.
//  rst mid-operation: next cycle matches the reset state exactly; in-flight tracking discarded.
// TESTING
//  - add r3,r1,r2 then sub r4,r3,r5 back-to-back -> fwd_a=01 in sub's EX cycle, no stall.
//  - add r3 ; nop ; or r6,r1,r3 -> fwd_b=10 for or; with one more nop -> fwd_b=00.
//  - lw r3 then add r4,r3,r1 -> exactly one cycle stall_ifid=1/bubble_ex=1, then fwd_a=10; evt_cnt=1.
//  - Writes to r0 followed by a reader of r0 -> fwd=00, no stall.
//  - ex_redirect with REDIR_CYC=2 -> flush_ifid high 2 cycles.
//  - ex_redirect coincident with a load-use stall -> stall_ifid=0, flush_ifid=1.
//  - syscall -> DRAIN, halted=1 exactly 3 cycles after issue (slots empty).
//  - Branch taken in EX while in DRAIN -> back to RUN, halted stays 0.
//  - rst asserted during DRAIN -> next cycle state RUN, all outputs 0.

Source files
------------

// File: rtl/hazard_sched.sv
// Hazard/issue scheduler beside decode: load-use stalls, EX forwarding selects, redirect flush, halt drain.
// Latency: stall/bubble/flush are combinational; fwd_a/fwd_b, halted and evt_cnt are registered.
// Backpressure: stall_ifid holds PC and IF/ID; while stalled, flushed, draining or halted nothing is issued.
module hazard_sched #(
  parameter int REDIR_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_halt,
  input  logic             ex_redirect,
  output logic             stall_ifid,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  // Counter holds the flush cycles still owed after the redirect cycle itself.
  localparam int RW = (REDIR_CYC > 1) ? $clog2(REDIR_CYC) : 1;
  localparam logic [RW-1:0] REDIR_RELOAD = RW'(REDIR_CYC - 1);

  state_t           state_q, state_d;
  logic [RW-1:0]    redir_q, redir_d;
  logic             ex_v_q, ex_wr_q, ex_ld_q, mem_v_q, mem_wr_q, mem_ld_q, wb_v_q, wb_wr_q, wb_ld_q;
  logic             ex_v_d, ex_wr_d, ex_ld_d, mem_v_d, mem_wr_d, mem_ld_d, wb_v_d, wb_wr_d, wb_ld_d;
  logic [4:0]       ex_rd_q, mem_rd_q, wb_rd_q, ex_rd_d, mem_rd_d, wb_rd_d;
  logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] evt_q, evt_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic ld_use, flush, issue;

  // Source/destination matches against in-flight writers; r0 never matches.
  always_comb begin
    ex_hit_a  = ex_v_q & ex_wr_q & (ex_rd_q != 5'd0) & id_use_rs & (id_rs == ex_rd_q);
    ex_hit_b  = ex_v_q & ex_wr_q & (ex_rd_q != 5'd0) & id_use_rt & (id_rt == ex_rd_q);
    mem_hit_a = mem_v_q & mem_wr_q & (mem_rd_q != 5'd0) & id_use_rs & (id_rs == mem_rd_q);
    mem_hit_b = mem_v_q & mem_wr_q & (mem_rd_q != 5'd0) & id_use_rt & (id_rt == mem_rd_q);
    ld_use    = id_valid & ex_ld_q & (ex_hit_a | ex_hit_b);
    flush     = (state_q != HALTED) & (ex_redirect | (redir_q != '0));
  end

  // FSM next state, stall/flush/bubble outputs, slot shifting and forwarding selects.
  always_comb begin
    state_d    = state_q;
    redir_d    = redir_q;
    stall_ifid = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    issue      = 1'b0;
    fwd_a_d    = 2'b00;
    fwd_b_d    = 2'b00;
    evt_d      = evt_q;
    ex_v_d  = ex_v_q;  ex_wr_d  = ex_wr_q;  ex_ld_d  = ex_ld_q;  ex_rd_d  = ex_rd_q;
    mem_v_d = mem_v_q; mem_wr_d = mem_wr_q; mem_ld_d = mem_ld_q; mem_rd_d = mem_rd_q;
    wb_v_d  = wb_v_q;  wb_wr_d  = wb_wr_q;  wb_ld_d  = wb_ld_q;  wb_rd_d  = wb_rd_q;

    case (state_q)
      RUN: begin
        // A redirect squashes the stalled instruction anyway, so it wins over the stall.
        flush_ifid = flush;
        stall_ifid = ld_use & ~flush;
        bubble_ex  = flush | ld_use;
        issue      = id_valid & ~stall_ifid & ~flush;
        if (issue && id_halt) state_d = DRAIN;
      end
      DRAIN: begin
        flush_ifid = flush;
        stall_ifid = ~flush;
        bubble_ex  = flush;
        // The halt is the youngest in flight: once EX and MEM are empty, the last
        // occupant retires from WB at this edge and the pipe is empty.
        if (ex_redirect) state_d = RUN;
        else if (!ex_v_q && !mem_v_q) state_d = HALTED;
      end
      HALTED: begin
        stall_ifid = 1'b1;
        bubble_ex  = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (state_q != HALTED) begin
      if (ex_redirect) redir_d = REDIR_RELOAD;
      else if (redir_q != '0) redir_d = redir_q - RW'(1);

      ex_v_d  = issue;   ex_wr_d  = id_wr_en; ex_ld_d  = id_is_load; ex_rd_d  = id_wr_reg;
      mem_v_d = ex_v_q;  mem_wr_d = ex_wr_q;  mem_ld_d = ex_ld_q;    mem_rd_d = ex_rd_q;
      wb_v_d  = mem_v_q; wb_wr_d  = mem_wr_q; wb_ld_d  = mem_ld_q;   wb_rd_d  = mem_rd_q;
    end

    // Youngest producer wins; WB needs no bypass because the regfile writes first half-cycle.
    if (issue) begin
      fwd_a_d = ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
      fwd_b_d = ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);
    end

    halted_d = (state_d == HALTED);

    if ((state_q == RUN) && (stall_ifid || flush_ifid) && (evt_q != '1))
      evt_d = evt_q + CNT_W'(1);
  end

  // State, tracking slots and registered outputs; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      redir_q  <= '0;
      ex_v_q   <= 1'b0; ex_wr_q  <= 1'b0; ex_ld_q  <= 1'b0; ex_rd_q  <= 5'd0;
      mem_v_q  <= 1'b0; mem_wr_q <= 1'b0; mem_ld_q <= 1'b0; mem_rd_q <= 5'd0;
      wb_v_q   <= 1'b0; wb_wr_q  <= 1'b0; wb_ld_q  <= 1'b0; wb_rd_q  <= 5'd0;
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
      halted_q <= 1'b0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      redir_q  <= redir_d;
      ex_v_q   <= ex_v_d;  ex_wr_q  <= ex_wr_d;  ex_ld_q  <= ex_ld_d;  ex_rd_q  <= ex_rd_d;
      mem_v_q  <= mem_v_d; mem_wr_q <= mem_wr_d; mem_ld_q <= mem_ld_d; mem_rd_q <= mem_rd_d;
      wb_v_q   <= wb_v_d;  wb_wr_q  <= wb_wr_d;  wb_ld_q  <= wb_ld_d;  wb_rd_q  <= wb_rd_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      halted_q <= halted_d;
      evt_q    <= evt_d;
    end
  end

  assign fwd_a   = fwd_a_q;
  assign fwd_b   = fwd_b_q;
  assign halted  = halted_q;
  assign evt_cnt = evt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: stimulus queues the expected output word per cycle,
// a negedge monitor pops and compares. Instance uses REDIR_CYC=2 and CNT_W=4 so the
// two-cycle flush and counter saturation are reachable.
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_halt, ex_redirect;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       stall_ifid, bubble_ex, flush_ifid, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] evt_cnt;

  hazard_sched #(.REDIR_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .stall_ifid(stall_ifid), .bubble_ex(bubble_ex), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
    logic we; logic [4:0] wd; logic ld; logic hlt;
  } ins_t;

  typedef struct {
    string      nm;
    logic [11:0] ex;
  } chk_t;

  chk_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic [11:0] act;
  assign act = {stall_ifid, bubble_ex, flush_ifid, fwd_a, fwd_b, halted, evt_cnt};

  function automatic logic [11:0] e(input logic st, bu, fl, input logic [1:0] fa, fb,
                                    input logic h, input logic [3:0] cnt);
    return {st, bu, fl, fa, fb, h, cnt};
  endfunction

  function automatic ins_t alu(input logic [4:0] rs, rt, wd);
    ins_t r;
    r = '0; r.v = 1'b1; r.rs = rs; r.rt = rt; r.urs = 1'b1; r.urt = 1'b1; r.we = 1'b1; r.wd = wd;
    return r;
  endfunction

  function automatic ins_t lw(input logic [4:0] rs, wd);
    ins_t r;
    r = '0; r.v = 1'b1; r.rs = rs; r.urs = 1'b1; r.we = 1'b1; r.wd = wd; r.ld = 1'b1;
    return r;
  endfunction

  function automatic ins_t nop();
    ins_t r;
    r = '0; r.v = 1'b1;
    return r;
  endfunction

  function automatic ins_t hlt();
    ins_t r;
    r = '0; r.v = 1'b1; r.hlt = 1'b1;
    return r;
  endfunction

  function automatic ins_t idle();
    ins_t r;
    r = '0;
    return r;
  endfunction

  // Drive one cycle of ID inputs (called just after a rising edge) and queue its expectation.
  task automatic step(input ins_t i, input logic rdr, input logic chk, input logic [11:0] ex,
                      input string nm);
    chk_t c;
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_use_rs = i.urs; id_use_rt = i.urt;
    id_wr_en = i.we; id_wr_reg = i.wd; id_is_load = i.ld; id_halt = i.hlt; ex_redirect = rdr;
    if (chk) begin
      c.nm = nm; c.ex = ex;
      q.push_back(c);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wr_en = 0; id_wr_reg = 0; id_is_load = 0; id_halt = 0; ex_redirect = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every cycle with a queued expectation, compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      tests++;
      if (act !== c.ex) begin
        fails++;
        $display("FAIL %s: got {st,bu,fl,fa,fb,h,cnt}=%b want %b", c.nm, act, c.ex);
      end
    end
  end

  initial begin
    do_reset();
    do_reset();

    // Reset state
    step(idle(), 0, 1, e(0,0,0,0,0,0,0), "reset_state");

    // add r3,r1,r2 ; sub r4,r3,r5 back-to-back -> fwd_a=01 in sub's EX cycle
    do_reset();
    step(alu(1,2,3), 0, 1, e(0,0,0,0,0,0,0), "exfwd_add");
    step(alu(3,5,4), 0, 1, e(0,0,0,0,0,0,0), "exfwd_sub_nostall");
    step(idle(),     0, 1, e(0,0,0,2'b01,0,0,0), "exfwd_fwd_a_01");
    step(idle(),     0, 1, e(0,0,0,0,0,0,0), "exfwd_idle_00");

    // add r3 ; nop ; or r6,r1,r3 -> fwd_b=10
    do_reset();
    step(alu(1,2,3), 0, 0, '0, "");
    step(nop(),      0, 0, '0, "");
    step(alu(1,3,6), 0, 1, e(0,0,0,0,0,0,0), "memfwd_or_nostall");
    step(idle(),     0, 1, e(0,0,0,0,2'b10,0,0), "memfwd_fwd_b_10");

    // add r3 ; nop ; nop ; or -> fwd_b=00 (WB covered by regfile)
    do_reset();
    step(alu(1,2,3), 0, 0, '0, "");
    step(nop(),      0, 0, '0, "");
    step(nop(),      0, 0, '0, "");
    step(alu(1,3,6), 0, 0, '0, "");
    step(idle(),     0, 1, e(0,0,0,0,0,0,0), "wbfwd_fwd_b_00");

    // lw r3 ; add r4,r3,r1 -> one stall cycle, then fwd_a=10, evt_cnt=1
    do_reset();
    step(lw(1,3),    0, 1, e(0,0,0,0,0,0,0), "lduse_lw");
    step(alu(3,1,4), 0, 1, e(1,1,0,0,0,0,0), "lduse_stall");
    step(alu(3,1,4), 0, 1, e(0,0,0,0,0,0,1), "lduse_release");
    step(idle(),     0, 1, e(0,0,0,2'b10,0,0,1), "lduse_fwd_a_10");

    // lw r0 ; reader of r0 -> no stall, fwd 00
    do_reset();
    step(lw(1,0),    0, 0, '0, "");
    step(alu(0,0,4), 0, 1, e(0,0,0,0,0,0,0), "r0_nostall");
    step(idle(),     0, 1, e(0,0,0,0,0,0,0), "r0_fwd_00");

    // Redirect, REDIR_CYC=2: flush two cycles; flushed instruction is not tracked
    do_reset();
    step(alu(1,2,3), 1, 1, e(0,1,1,0,0,0,0), "redir_c0");
    step(alu(1,2,3), 0, 1, e(0,1,1,0,0,0,1), "redir_c1");
    step(alu(3,5,4), 0, 1, e(0,0,0,0,0,0,2), "redir_done");
    step(idle(),     0, 1, e(0,0,0,0,0,0,2), "redir_no_fwd");

    // Redirect during an active flush restarts the count
    do_reset();
    step(idle(), 1, 1, e(0,1,1,0,0,0,0), "restart_c0");
    step(idle(), 1, 1, e(0,1,1,0,0,0,1), "restart_c1");
    step(idle(), 0, 1, e(0,1,1,0,0,0,2), "restart_c2");
    step(idle(), 0, 1, e(0,0,0,0,0,0,3), "restart_c3");

    // Redirect coincident with load-use stall -> stall_ifid=0, flush_ifid=1
    do_reset();
    step(lw(1,3),    0, 0, '0, "");
    step(alu(3,1,4), 1, 1, e(0,1,1,0,0,0,0), "redir_over_stall");
    step(idle(),     0, 1, e(0,1,1,0,0,0,1), "redir_over_stall_c1");
    step(idle(),     0, 1, e(0,0,0,0,0,0,2), "redir_over_stall_c2");

    // syscall -> DRAIN, halted exactly 3 edges after the issuing edge; redirect ignored once halted
    do_reset();
    step(hlt(),  0, 1, e(0,0,0,0,0,0,0), "halt_issue");
    step(idle(), 0, 1, e(1,0,0,0,0,0,0), "drain_c1");
    step(idle(), 0, 1, e(1,0,0,0,0,0,0), "drain_c2");
    step(idle(), 0, 1, e(1,0,0,0,0,0,0), "drain_c3");
    step(idle(), 0, 1, e(1,1,0,0,0,1,0), "halted_c4");
    step(alu(1,2,3), 1, 1, e(1,1,0,0,0,1,0), "halted_ignore_redir");
    step(idle(), 0, 1, e(1,1,0,0,0,1,0), "halted_hold");

    // Branch taken while draining -> back to RUN, halted stays 0
    do_reset();
    step(hlt(),      0, 0, '0, "");
    step(idle(),     0, 1, e(1,0,0,0,0,0,0), "drkill_drain");
    step(idle(),     1, 1, e(0,1,1,0,0,0,0), "drkill_redirect");
    step(idle(),     0, 1, e(0,1,1,0,0,0,0), "drkill_flush2");
    step(alu(1,2,3), 0, 1, e(0,0,0,0,0,0,1), "drkill_run_issue");
    step(alu(3,5,4), 0, 1, e(0,0,0,0,0,0,1), "drkill_run_sub");
    step(idle(),     0, 1, e(0,0,0,2'b01,0,0,1), "drkill_fwd_a_01");

    // rst while draining -> next cycle RUN with all outputs 0, tracking discarded
    do_reset();
    step(lw(1,3), 0, 0, '0, "");
    step(hlt(),   0, 0, '0, "");
    step(idle(),  0, 1, e(1,0,0,0,0,0,0), "rstdrain_draining");
    do_reset();
    step(alu(3,1,4), 0, 1, e(0,0,0,0,0,0,0), "rstdrain_outputs_0");
    step(idle(),     0, 1, e(0,0,0,0,0,0,0), "rstdrain_fwd_00");

    // Counter saturates at 2^CNT_W-1
    do_reset();
    for (int i = 0; i < 18; i++) step(idle(), 1, 0, '0, "");
    step(idle(), 0, 1, e(0,1,1,0,0,0,4'hF), "evt_saturated");
    step(idle(), 0, 1, e(0,0,0,0,0,0,4'hF), "evt_hold");

    step(idle(), 0, 0, '0, "");
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
